ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX bundle (WB/M control, regdst/alusrc/aluop, npc, read data, sign-extended immediate, rt/rd fields) and produces the registered EX/MEM bundle. It performs ALU control decode, ALU operation, branch-target add and destination-register select. A multi-cycle shift-add MUL stalls upstream through a busy handshake.

Parameters:
WIDTH, 32, datapath width (only 32 supported)
MUL_CYCLES, 32, shift-add iterations per MUL

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
in_valid  in  1  ID/EX bundle holds a real instruction
ctlwb_in  in  2  WB control, passed through
ctlm_in  in  3  M control, passed through
regdst  in  1  1: dest=rd (instr_1511); 0: dest=rt (instr_2016)
alusrc  in  1  1: operand B = s_extend; 0: rdata2
aluop  in  2  ALU op class
npc  in  32  PC+4 of instruction
rdata1  in  32  rs value
rdata2  in  32  rt value
s_extend  in  32  sign-extended immediate; [5:0] = funct
instr_2016  in  5  rt field
instr_1511  in  5  rd field
mem_stall  in  1  downstream cannot accept; hold EX/MEM
flush  in  1  kill instruction in EX
ex_busy  out  1  upstream must hold ID/EX contents
out_valid  out  1  EX/MEM holds a real instruction
wb_ctlout  out  2  registered WB control
m_ctlout  out  3  registered M control
add_result  out  32  npc + (s_extend << 2), wraps mod 2^32
zero  out  1  alu_result == 0
alu_result  out  32  ALU / MUL low word
rdata2out  out  32  registered rdata2 (store data)
muxout  out  5  destination register

Behaviour:
- Reset (rst=1 at edge): every output register = 0; FSM = IDLE; MUL counter/accumulator = 0. Priority is rst > flush > mem_stall.
- ALU control:
  - aluop 00 = ADD; 01 = SUB; 11 = OR.
  - aluop 10 decodes funct = s_extend[5:0]: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT (signed, result 1/0), 0x18 MUL. Any other funct = ADD.
  - ADD/SUB wrap mod 2^32.
- FSM states: IDLE, MUL, DONE.
- IDLE, non-MUL, mem_stall=0: at the edge, EX/MEM loads the computed values. out_valid <= in_valid. If in_valid=0, wb_ctlout and m_ctlout are loaded as 0 (bubble). Latency is 1 cycle.
- IDLE, in_valid=1 and MUL decoded, mem_stall=0: at the edge, latch multiplicand and multiplier (B = alusrc mux), count <= 0, go to MUL. EX/MEM loads a bubble (out_valid=0, ctl=0).
- MUL: one shift-add step per cycle. When count == MUL_CYCLES-1, go to DONE with the product low 32 bits held internally.
- MUL ignores mem_stall.
- DONE, mem_stall=0: EX/MEM loads the product, ctl and muxout from the held ID/EX inputs, out_valid=1; go to IDLE.
- DONE, mem_stall=1: stay in DONE.
- ex_busy (combinational) = mem_stall | (state==MUL) | (state==IDLE & in_valid & MUL decoded).
  - ex_busy is low in DONE, so upstream advances exactly once per MUL and the MUL is never re-accepted.
  - MUL busy span = 33 cycles (accept cycle + 32 MUL cycles).
- mem_stall=1, not in MUL: all EX/MEM outputs hold; FSM does not advance from IDLE/DONE.
- flush=1 at edge:
  - out_valid, wb_ctlout, m_ctlout <= 0; data outputs unspecified-but-held.
  - FSM forced to IDLE, aborting MUL/DONE; the instruction is dropped with no writeback.
- zero and add_result are registered with alu_result. add_result is computed for every instruction.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> every output 0, ex_busy=0 (mem_stall=0).
- R-type ADD: aluop=10, funct=0x20, rdata1=0xFFFFFFFF, rdata2=2, regdst=1, rd=9 -> next edge alu_result=1, muxout=9, zero=0, out_valid=1.
- BEQ: aluop=01, rdata1=rdata2=5, npc=0x100, s_extend=0xFFFFFFFE -> alu_result=0, zero=1, add_result=0x000000F8.
- SLT signed: funct=0x2A, rdata1=0x80000000, rdata2=1 -> alu_result=1. Swapped operands -> 0.
- MUL: funct=0x18, rdata1=7, rdata2=0xFFFFFFFD.
  - ex_busy high 33 cycles, out_valid=0 meanwhile.
  - Then alu_result=0xFFFFFFEB, out_valid=1 for one instruction only.
- Flush/stall:
  - flush at MUL count 10 -> IDLE next cycle, out_valid=0, no product emitted.
  - mem_stall held 3 cycles after ADD -> outputs frozen, ex_busy=1.

Source files
------------

// File: rtl/ex_stage_unit.sv
// Execute stage of the 5-stage MIPS pipeline: ALU control and datapath, branch-target
// adder, destination-register select and a stalling shift-add multiplier feeding EX/MEM.
module ex_stage_unit #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       ctlwb_in,
    input  logic [2:0]       ctlm_in,
    input  logic             regdst,
    input  logic             alusrc,
    input  logic [1:0]       aluop,
    input  logic [WIDTH-1:0] npc,
    input  logic [WIDTH-1:0] rdata1,
    input  logic [WIDTH-1:0] rdata2,
    input  logic [WIDTH-1:0] s_extend,
    input  logic [4:0]       instr_2016,
    input  logic [4:0]       instr_1511,
    input  logic             mem_stall,
    input  logic             flush,
    output logic             ex_busy,
    output logic             out_valid,
    output logic [1:0]       wb_ctlout,
    output logic [2:0]       m_ctlout,
    output logic [WIDTH-1:0] add_result,
    output logic             zero,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] rdata2out,
    output logic [4:0]       muxout
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_SLT = 3'd4,
        OP_MUL = 3'd5
    } alu_op_t;

    state_t           state_r;
    state_t           next_state_s;
    alu_op_t          alu_op_s;
    logic [WIDTH-1:0] operand_b_s;
    logic [WIDTH-1:0] alu_value_s;
    logic [WIDTH-1:0] branch_target_s;
    logic [4:0]       dest_s;
    logic             mul_decoded_s;
    logic             accept_s;
    logic             load_alu_s;
    logic             load_done_s;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] count_r;

    assign operand_b_s     = alusrc ? s_extend : rdata2;
    assign branch_target_s = npc + {s_extend[WIDTH-3:0], 2'b00};
    assign dest_s          = regdst ? instr_1511 : instr_2016;
    assign mul_decoded_s   = in_valid && (alu_op_s == OP_MUL);
    assign ex_busy         = mem_stall | (state_r == ST_MUL) | ((state_r == ST_IDLE) & mul_decoded_s);

    // ALU control: aluop class, with funct decode for R-type
    always_comb begin
        alu_op_s = OP_ADD;
        case (aluop)
            2'b00: alu_op_s = OP_ADD;
            2'b01: alu_op_s = OP_SUB;
            2'b11: alu_op_s = OP_OR;
            2'b10: begin
                case (s_extend[5:0])
                    6'h20:   alu_op_s = OP_ADD;
                    6'h22:   alu_op_s = OP_SUB;
                    6'h24:   alu_op_s = OP_AND;
                    6'h25:   alu_op_s = OP_OR;
                    6'h2A:   alu_op_s = OP_SLT;
                    6'h18:   alu_op_s = OP_MUL;
                    default: alu_op_s = OP_ADD;
                endcase
            end
            default: alu_op_s = OP_ADD;
        endcase
    end

    // Single-cycle ALU; MUL goes through the iterative datapath instead
    always_comb begin
        alu_value_s = {WIDTH{1'b0}};
        case (alu_op_s)
            OP_ADD:  alu_value_s = rdata1 + operand_b_s;
            OP_SUB:  alu_value_s = rdata1 - operand_b_s;
            OP_AND:  alu_value_s = rdata1 & operand_b_s;
            OP_OR:   alu_value_s = rdata1 | operand_b_s;
            OP_SLT:  alu_value_s = ($signed(rdata1) < $signed(operand_b_s)) ?
                                   {{(WIDTH-1){1'b0}}, 1'b1} : {WIDTH{1'b0}};
            OP_MUL:  alu_value_s = {WIDTH{1'b0}};
            default: alu_value_s = rdata1 + operand_b_s;
        endcase
    end

    // Next-state and load strobes; flush overrides these in the registers
    always_comb begin
        next_state_s = state_r;
        accept_s     = 1'b0;
        load_alu_s   = 1'b0;
        load_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!mem_stall) begin
                    if (mul_decoded_s) begin
                        next_state_s = ST_MUL;
                        accept_s     = 1'b1;
                    end else begin
                        next_state_s = ST_IDLE;
                        load_alu_s   = 1'b1;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (count_r == CNT_LAST) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_MUL;
                end
            end
            ST_DONE: begin
                if (!mem_stall) begin
                    next_state_s = ST_IDLE;
                    load_done_s  = 1'b1;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Shift-add multiplier: one partial product accumulated per MUL cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (!flush && accept_s) begin
            mcand_r  <= rdata1;
            mplier_r <= operand_b_s;
            acc_r    <= {WIDTH{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (!flush && (state_r == ST_MUL)) begin
            acc_r    <= acc_r + (mplier_r[0] ? mcand_r : {WIDTH{1'b0}});
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            count_r  <= count_r + CNT_ONE;
        end
    end

    // EX/MEM pipeline register; data fields hold across flush and bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            wb_ctlout  <= 2'b00;
            m_ctlout   <= 3'b000;
            add_result <= {WIDTH{1'b0}};
            zero       <= 1'b0;
            alu_result <= {WIDTH{1'b0}};
            rdata2out  <= {WIDTH{1'b0}};
            muxout     <= 5'd0;
        end else if (flush) begin
            out_valid <= 1'b0;
            wb_ctlout <= 2'b00;
            m_ctlout  <= 3'b000;
        end else if (load_done_s) begin
            out_valid  <= 1'b1;
            wb_ctlout  <= ctlwb_in;
            m_ctlout   <= ctlm_in;
            add_result <= branch_target_s;
            zero       <= (acc_r == {WIDTH{1'b0}});
            alu_result <= acc_r;
            rdata2out  <= rdata2;
            muxout     <= dest_s;
        end else if (accept_s) begin
            out_valid <= 1'b0;
            wb_ctlout <= 2'b00;
            m_ctlout  <= 3'b000;
        end else if (load_alu_s) begin
            out_valid  <= in_valid;
            wb_ctlout  <= in_valid ? ctlwb_in : 2'b00;
            m_ctlout   <= in_valid ? ctlm_in : 3'b000;
            add_result <= branch_target_s;
            zero       <= (alu_value_s == {WIDTH{1'b0}});
            alu_result <= alu_value_s;
            rdata2out  <= rdata2;
            muxout     <= dest_s;
        end
    end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Randomized bench for ex_stage_unit against a cycle-level behavioural model,
// plus directed cases with hand-computed expectations.
module tb_ex_stage_unit;

    logic        clk = 1'b0;
    logic        rst, in_valid, regdst, alusrc, mem_stall, flush;
    logic [1:0]  ctlwb_in, aluop;
    logic [2:0]  ctlm_in;
    logic [31:0] npc, rdata1, rdata2, s_extend;
    logic [4:0]  instr_2016, instr_1511;
    logic        ex_busy, out_valid, zero;
    logic [1:0]  wb_ctlout;
    logic [2:0]  m_ctlout;
    logic [31:0] add_result, alu_result, rdata2out;
    logic [4:0]  muxout;

    int vectors = 0;
    int errors  = 0;

    // behavioural model state
    logic        e_valid, e_zero;
    logic [1:0]  e_wb;
    logic [2:0]  e_m;
    logic [31:0] e_add, e_alu, e_rd2, mul_prod;
    logic [4:0]  e_mux;
    int          mul_left = 0;
    bit          mul_done = 1'b0;
    logic        busy_seen, adv_ok;

    always #5 clk = ~clk;

    ex_stage_unit #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .ctlwb_in(ctlwb_in), .ctlm_in(ctlm_in),
        .regdst(regdst), .alusrc(alusrc), .aluop(aluop), .npc(npc), .rdata1(rdata1),
        .rdata2(rdata2), .s_extend(s_extend), .instr_2016(instr_2016), .instr_1511(instr_1511),
        .mem_stall(mem_stall), .flush(flush), .ex_busy(ex_busy), .out_valid(out_valid),
        .wb_ctlout(wb_ctlout), .m_ctlout(m_ctlout), .add_result(add_result), .zero(zero),
        .alu_result(alu_result), .rdata2out(rdata2out), .muxout(muxout)
    );

    function automatic bit ref_is_mul(input logic [1:0] op, input logic [5:0] f);
        return (op == 2'b10) && (f == 6'h18);
    endfunction

    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b00) return a + b;
        if (op == 2'b01) return a - b;
        if (op == 2'b11) return a | b;
        case (f)
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_model(input logic [31:0] val, input logic v);
        e_valid = v;
        e_wb    = v ? ctlwb_in : 2'b00;
        e_m     = v ? ctlm_in : 3'b000;
        e_alu   = val;
        e_zero  = (val == 32'd0);
        e_add   = npc + (s_extend << 2);
        e_rd2   = rdata2;
        e_mux   = regdst ? instr_1511 : instr_2016;
    endtask

    // One clock: check ex_busy, advance the model, then compare EX/MEM after the edge
    task automatic step();
        logic [31:0] opb;
        logic        eb;
        #1;
        opb = alusrc ? s_extend : rdata2;
        if (!rst) begin
            eb = mem_stall || (mul_left > 0) ||
                 (!mul_done && in_valid && ref_is_mul(aluop, s_extend[5:0]));
            check("ex_busy", 32'(ex_busy), 32'(eb));
        end
        busy_seen = ex_busy;
        adv_ok    = !ex_busy || flush || rst;
        if (rst) begin
            e_valid = 1'b0; e_wb = 2'b00; e_m = 3'b000; e_add = 32'd0; e_zero = 1'b0;
            e_alu = 32'd0; e_rd2 = 32'd0; e_mux = 5'd0; mul_left = 0; mul_done = 1'b0;
        end else if (flush) begin
            e_valid = 1'b0; e_wb = 2'b00; e_m = 3'b000; mul_left = 0; mul_done = 1'b0;
        end else if (mul_left > 0) begin
            mul_left--;
            if (mul_left == 0) mul_done = 1'b1;
        end else if (mem_stall) begin
            e_valid = e_valid;
        end else if (mul_done) begin
            load_model(mul_prod, 1'b1);
            mul_done = 1'b0;
        end else if (in_valid && ref_is_mul(aluop, s_extend[5:0])) begin
            mul_prod = rdata1 * opb;
            mul_left = 32;
            e_valid = 1'b0; e_wb = 2'b00; e_m = 3'b000;
        end else begin
            load_model(ref_alu(aluop, s_extend[5:0], rdata1, opb), in_valid);
        end
        @(posedge clk);
        #1;
        check("out_valid", 32'(out_valid), 32'(e_valid));
        check("wb_ctlout", 32'(wb_ctlout), 32'(e_wb));
        check("m_ctlout", 32'(m_ctlout), 32'(e_m));
        if (e_valid) begin
            check("alu_result", alu_result, e_alu);
            check("zero", 32'(zero), 32'(e_zero));
            check("add_result", add_result, e_add);
            check("rdata2out", rdata2out, e_rd2);
            check("muxout", 32'(muxout), 32'(e_mux));
        end
    endtask

    task automatic rand_instr();
        logic [31:0] t;
        logic [5:0]  f;
        case ($urandom_range(0, 12))
            0:       f = 6'h18;
            1, 2:    f = 6'h20;
            3, 4:    f = 6'h22;
            5, 6:    f = 6'h24;
            7, 8:    f = 6'h25;
            9, 10:   f = 6'h2A;
            default: f = 6'($urandom_range(0, 63));
        endcase
        t          = $urandom();
        in_valid   = ($urandom_range(0, 3) != 0);
        ctlwb_in   = 2'($urandom_range(0, 3));
        ctlm_in    = 3'($urandom_range(0, 7));
        regdst     = 1'($urandom_range(0, 1));
        alusrc     = 1'($urandom_range(0, 1));
        aluop      = 2'($urandom_range(0, 3));
        npc        = $urandom();
        rdata1     = $urandom();
        rdata2     = ($urandom_range(0, 3) == 0) ? rdata1 : $urandom();
        s_extend   = {t[31:6], f};
        instr_2016 = 5'($urandom_range(0, 31));
        instr_1511 = 5'($urandom_range(0, 31));
    endtask

    task automatic set_r(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1; aluop = 2'b10; alusrc = 1'b0; regdst = 1'b1;
        s_extend = {26'd0, f}; rdata1 = a; rdata2 = b;
        ctlwb_in = 2'b10; ctlm_in = 3'b001; npc = 32'h0000_0040;
        instr_1511 = 5'd9; instr_2016 = 5'd3;
    endtask

    initial begin
        int n;
        rst = 1'b1; mem_stall = 1'b0; flush = 1'b0;
        rand_instr();
        aluop = 2'b00;
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_ctl", {27'd0, wb_ctlout, m_ctlout}, 32'd0);
        check("rst_alu_result", alu_result, 32'd0);
        check("rst_add_result", add_result, 32'd0);
        check("rst_rdata2out", rdata2out, 32'd0);
        check("rst_muxout_zero", {26'd0, muxout, zero}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_ex_busy", 32'(ex_busy), 32'd0);

        // R-type ADD with wrap
        set_r(6'h20, 32'hFFFF_FFFF, 32'd2);
        step();
        check("add_alu", alu_result, 32'd1);
        check("add_muxout", 32'(muxout), 32'd9);
        check("add_zero", 32'(zero), 32'd0);
        check("add_valid", 32'(out_valid), 32'd1);

        // BEQ compare and backward branch target
        set_r(6'h00, 32'd5, 32'd5);
        aluop = 2'b01; npc = 32'h0000_0100; s_extend = 32'hFFFF_FFFE;
        step();
        check("beq_alu", alu_result, 32'd0);
        check("beq_zero", 32'(zero), 32'd1);
        check("beq_add_result", add_result, 32'h0000_00F8);

        // signed SLT both ways
        set_r(6'h2A, 32'h8000_0000, 32'd1);
        step();
        check("slt_neg_lt", alu_result, 32'd1);
        set_r(6'h2A, 32'd1, 32'h8000_0000);
        step();
        check("slt_swapped", alu_result, 32'd0);

        // MUL: 33 busy cycles, then one product
        set_r(6'h18, 32'd7, 32'hFFFF_FFFD);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!busy_seen) break;
            n++;
            check("mul_bubble", 32'(out_valid), 32'd0);
        end
        check("mul_busy_span", 32'(n), 32'd33);
        check("mul_product", alu_result, 32'hFFFF_FFEB);
        check("mul_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        step();
        check("mul_once", 32'(out_valid), 32'd0);

        // flush aborts a MUL at count 10
        set_r(6'h18, 32'd3, 32'd5);
        step();
        repeat (10) step();
        flush = 1'b1;
        step();
        check("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_idle_busy", 32'(ex_busy), 32'd0);
        for (int i = 0; i < 40; i++) begin
            step();
            check("flush_no_product", 32'(out_valid), 32'd0);
        end

        // mem_stall freezes EX/MEM after an ADD
        set_r(6'h20, 32'd10, 32'd20);
        step();
        check("stall_add", alu_result, 32'd30);
        mem_stall = 1'b1;
        rand_instr();
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_busy", 32'(busy_seen), 32'd1);
            check("stall_hold_alu", alu_result, 32'd30);
            check("stall_hold_valid", 32'(out_valid), 32'd1);
        end
        mem_stall = 1'b0;

        // randomized traffic; upstream only advances when the stage accepted
        for (int i = 0; i < 4000; i++) begin
            if (adv_ok) rand_instr();
            mem_stall = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
